// File: rtl/arima_mem_pkg.sv
// ---------------------------------------------------------------------------
// arima_mem_pkg
// Shared types and defaults for the ARIMA sample-RAM arbiter.
//   arb_state_t : arbiter mode (RUN / DRAIN / LOAD)
//   arb_gnt_t   : one-hot grant vector {ld, wr, rd}
// ---------------------------------------------------------------------------
package arima_mem_pkg;

  localparam int ARB_N_DEF  = 32;
  localparam int ARB_AW_DEF = 11;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} arb_state_t;

  typedef struct packed {
    logic ld;
    logic wr;
    logic rd;
  } arb_gnt_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// ---------------------------------------------------------------------------
// rd_valid_pipe
// Tracks granted reads through the RAM latency and captures read data.
//   clk_i       core clock
//   flush_i     synchronous flush (drops every read in flight)
//   push_i      a read was granted this cycle
//   mem_dout_i  RAM read data, RD_LAT cycles after the address
//   rd_valid_o  one pulse per granted read, RD_LAT cycles after the grant
//   rd_data_o   read data; holds the last returned word between pulses
//   busy_o      at least one read is still in flight
// ---------------------------------------------------------------------------
module rd_valid_pipe #(
  parameter int N      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [N-1:0] mem_dout_i,
  output logic         rd_valid_o,
  output logic [N-1:0] rd_data_o,
  output logic         busy_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [N-1:0]      data_q;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = push_i;
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (rd_valid_o) data_q <= mem_dout_i;
    end
  end

  // Gated by the flush so a read whose data would land in a reset cycle
  // never reports valid.
  assign rd_valid_o = vld_q[RD_LAT-1] & ~flush_i;
  assign rd_data_o  = rd_valid_o ? mem_dout_i : data_q;
  assign busy_o     = |vld_q;

endmodule

// File: rtl/arima_mem_arbiter.sv
// ---------------------------------------------------------------------------
// arima_mem_arbiter
// Shares the single-port sample RAM between datapath reads, prediction
// write-back and the host loader.  Writes beat reads unless a read has been
// refused MAX_WAIT cycles in a row.  The loader gets exclusive access only
// after all outstanding reads have returned.
//   clk_i / reset_i                   core clock, sync active-high reset
//   rd_req_i rd_addr_i                datapath read request
//   rd_gnt_o rd_valid_o rd_data_o     read grant, return strobe and data
//   wr_req_i wr_addr_i wr_data_i      write-back request, wr_gnt_o grant
//   ld_mode_i                         loader asks for exclusive ownership
//   ld_req_i ld_addr_i ld_data_i      loader write, ld_gnt_o grant
//   ld_ready_o                        arbiter is in LOAD
//   mem_en_o mem_we_o mem_addr_o mem_din_o mem_dout_i   RAM side
// Build option ARIMA_MEM_ARB_STATS_EN adds saturating 16-bit counters
//   rd_cnt_o wr_cnt_o ld_cnt_o stall_cnt_o for the debug display.
// ---------------------------------------------------------------------------
module arima_mem_arbiter
  import arima_mem_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int AW       = ARB_AW_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_gnt_o,
  output logic [N-1:0]  rd_data_o,
  output logic          rd_valid_o,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [N-1:0]  wr_data_i,
  output logic          wr_gnt_o,
  input  logic          ld_mode_i,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [N-1:0]  ld_data_i,
  output logic          ld_gnt_o,
  output logic          ld_ready_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [N-1:0]  mem_din_o,
`ifdef ARIMA_MEM_ARB_STATS_EN
  output logic [15:0]   rd_cnt_o,
  output logic [15:0]   wr_cnt_o,
  output logic [15:0]   ld_cnt_o,
  output logic [15:0]   stall_cnt_o,
`endif
  input  logic [N-1:0]  mem_dout_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  arb_state_t    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  arb_gnt_t      gnt;
  logic          rd_busy;

  always_comb begin
    gnt = '0;
    unique case (state_q)
      ST_RUN: begin
        // A loader request takes the cycle even if nobody else gets it.
        if (!ld_mode_i) begin
          if (rd_req_i && (wait_q == WAIT_MAX || !wr_req_i)) gnt.rd = 1'b1;
          else if (wr_req_i)                                 gnt.wr = 1'b1;
        end
      end
      ST_LOAD:  if (ld_mode_i) gnt.ld = ld_req_i;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (ld_mode_i) state_d = ST_DRAIN;
        if (gnt.rd || !rd_req_i)  wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
      end
      ST_DRAIN: begin
        if (!ld_mode_i)   state_d = ST_RUN;
        else if (!rd_busy) state_d = ST_LOAD;
      end
      ST_LOAD:  if (!ld_mode_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (gnt.rd) begin
      mem_addr_o = rd_addr_i;
    end else if (gnt.wr) begin
      mem_addr_o = wr_addr_i;
      mem_din_o  = wr_data_i;
    end else if (gnt.ld) begin
      mem_addr_o = ld_addr_i;
      mem_din_o  = ld_data_i;
    end
  end

  assign mem_en_o   = |gnt;
  assign mem_we_o   = gnt.wr | gnt.ld;
  assign rd_gnt_o   = gnt.rd;
  assign wr_gnt_o   = gnt.wr;
  assign ld_gnt_o   = gnt.ld;
  assign ld_ready_o = (state_q == ST_LOAD);

  rd_valid_pipe #(
    .N      (N),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i      (clk_i),
    .flush_i    (reset_i),
    .push_i     (gnt.rd),
    .mem_dout_i (mem_dout_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .busy_o     (rd_busy)
  );

`ifdef ARIMA_MEM_ARB_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, ld_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (state_q == ST_RUN) && (rd_req_i || wr_req_i || ld_req_i) && !(|gnt);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt.rd && rd_cnt_q != 16'hFFFF)    rd_cnt_q    <= rd_cnt_q + 16'd1;
      if (gnt.wr && wr_cnt_q != 16'hFFFF)    wr_cnt_q    <= wr_cnt_q + 16'd1;
      if (gnt.ld && ld_cnt_q != 16'hFFFF)    ld_cnt_q    <= ld_cnt_q + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign ld_cnt_o    = ld_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_arima_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_arima_mem_arbiter
// Directed scenarios followed by random traffic, each cycle compared with a
// transaction-level reference: a word array for RAM contents, a queue of
// reads awaiting return, a wait count and the arbiter mode.
// ---------------------------------------------------------------------------
module tb_arima_mem_arbiter;

  localparam int N        = 32;
  localparam int AW       = 11;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int M_RUN = 0, M_DRAIN = 1, M_LOAD = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          rd_req_i, wr_req_i, ld_mode_i, ld_req_i;
  logic [AW-1:0] rd_addr_i, wr_addr_i, ld_addr_i;
  logic [N-1:0]  wr_data_i, ld_data_i;
  logic          rd_gnt_o, rd_valid_o, wr_gnt_o, ld_gnt_o, ld_ready_o;
  logic          mem_en_o, mem_we_o;
  logic [N-1:0]  rd_data_o, mem_din_o, mem_dout_i;
  logic [AW-1:0] mem_addr_o;
`ifdef ARIMA_MEM_ARB_STATS_EN
  logic [15:0]   rd_cnt_o, wr_cnt_o, ld_cnt_o, stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  arima_mem_arbiter #(
    .N(N), .AW(AW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .ld_mode_i(ld_mode_i), .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .ld_gnt_o(ld_gnt_o), .ld_ready_o(ld_ready_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
`ifdef ARIMA_MEM_ARB_STATS_EN
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .ld_cnt_o(ld_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .mem_dout_i(mem_dout_i)
  );

  function automatic logic [N-1:0] seed_val(input int i);
    if (i == 5) return 32'h0000_1234;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural block RAM with RD_LAT read latency.
  logic         ram_ready = 1'b0;
  logic [N-1:0] ram [DEPTH];
  logic [N-1:0] dpipe [RD_LAT];
  always @(posedge clk_i) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed_val(i);
      ram_ready <= 1'b1;
    end else if (mem_en_o && mem_we_o) begin
      ram[mem_addr_o] <= mem_din_o;
    end
    if (mem_en_o && !mem_we_o) dpipe[0] <= ram[mem_addr_o];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_dout_i = dpipe[RD_LAT-1];

  // Reference model state.
  typedef struct { int due; logic [N-1:0] data; } pend_t;
  pend_t        pend[$];
  logic [N-1:0] ref_mem [DEPTH];
  logic [N-1:0] m_last;
  int           m_mode, m_wait, cyc;
  logic         e_rd, e_wr, e_ld;
`ifdef ARIMA_MEM_ARB_STATS_EN
  int           m_rdc, m_wrc, m_ldc, m_stc;
`endif

  // Observed outputs sampled at the falling edge of the last tick.
  logic          o_rd_gnt, o_wr_gnt, o_ld_gnt, o_ld_ready, o_rd_valid, o_mem_en, o_mem_we;
  logic [N-1:0]  o_rd_data;
  logic [AW-1:0] o_mem_addr;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic         e_valid, e_en, e_we, empty;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_din, e_data;
    @(negedge clk_i);
    o_rd_gnt = rd_gnt_o;  o_wr_gnt = wr_gnt_o;  o_ld_gnt = ld_gnt_o;
    o_ld_ready = ld_ready_o;  o_rd_valid = rd_valid_o;  o_rd_data = rd_data_o;
    o_mem_en = mem_en_o;  o_mem_we = mem_we_o;  o_mem_addr = mem_addr_o;

    e_rd = 1'b0; e_wr = 1'b0; e_ld = 1'b0;
    e_valid = !reset_i && pend.size() > 0 && pend[0].due == cyc;
    if (reset_i) begin
      chk("rst_rd_valid", 64'(rd_valid_o), 64'(0));
      m_mode = M_RUN; m_wait = 0; m_last = '0;
      pend.delete();
`ifdef ARIMA_MEM_ARB_STATS_EN
      m_rdc = 0; m_wrc = 0; m_ldc = 0; m_stc = 0;
`endif
    end else begin
      if (m_mode == M_RUN && !ld_mode_i) begin
        if (rd_req_i && (m_wait >= MAX_WAIT || !wr_req_i)) e_rd = 1'b1;
        else if (wr_req_i)                                 e_wr = 1'b1;
      end else if (m_mode == M_LOAD && ld_mode_i && ld_req_i) begin
        e_ld = 1'b1;
      end
      e_en   = e_rd | e_wr | e_ld;
      e_we   = e_wr | e_ld;
      e_addr = e_rd ? rd_addr_i : e_wr ? wr_addr_i : e_ld ? ld_addr_i : '0;
      e_din  = e_wr ? wr_data_i : e_ld ? ld_data_i : '0;
      e_data = e_valid ? pend[0].data : m_last;

      chk("rd_gnt",   64'(rd_gnt_o),   64'(e_rd));
      chk("wr_gnt",   64'(wr_gnt_o),   64'(e_wr));
      chk("ld_gnt",   64'(ld_gnt_o),   64'(e_ld));
      chk("ld_ready", 64'(ld_ready_o), 64'(m_mode == M_LOAD));
      chk("rd_valid", 64'(rd_valid_o), 64'(e_valid));
      chk("rd_data",  64'(rd_data_o),  64'(e_data));
      chk("mem_en",   64'(mem_en_o),   64'(e_en));
      chk("mem_we",   64'(mem_we_o),   64'(e_we));
      chk("mem_addr", 64'(mem_addr_o), 64'(e_addr));
      chk("mem_din",  64'(mem_din_o),  64'(e_din));
`ifdef ARIMA_MEM_ARB_STATS_EN
      chk("rd_cnt",    64'(rd_cnt_o),    64'(m_rdc));
      chk("wr_cnt",    64'(wr_cnt_o),    64'(m_wrc));
      chk("ld_cnt",    64'(ld_cnt_o),    64'(m_ldc));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stc));
      if (e_rd && m_rdc < 65535) m_rdc++;
      if (e_wr && m_wrc < 65535) m_wrc++;
      if (e_ld && m_ldc < 65535) m_ldc++;
      if (m_mode == M_RUN && (rd_req_i || wr_req_i || ld_req_i) && !e_en && m_stc < 65535) m_stc++;
`endif

      empty = (pend.size() == 0);
      if (e_valid) begin
        m_last = pend[0].data;
        void'(pend.pop_front());
      end
      if (e_rd) pend.push_back('{due: cyc + RD_LAT, data: ref_mem[rd_addr_i]});
      if (e_wr) ref_mem[wr_addr_i] = wr_data_i;
      if (e_ld) ref_mem[ld_addr_i] = ld_data_i;
      if (m_mode == M_RUN) begin
        if (e_rd || !rd_req_i) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
      end
      case (m_mode)
        M_RUN:   if (ld_mode_i) m_mode = M_DRAIN;
        M_DRAIN: if (!ld_mode_i) m_mode = M_RUN; else if (empty) m_mode = M_LOAD;
        default: if (!ld_mode_i) m_mode = M_RUN;
      endcase
    end
    cyc++;
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    rd_req_i = 1'b0; wr_req_i = 1'b0; ld_req_i = 1'b0; ld_mode_i = 1'b0;
  endtask

  initial begin
    bit got;
    cyc = 0; m_mode = M_RUN; m_wait = 0; m_last = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
    idle();
    rd_addr_i = '0; wr_addr_i = '0; ld_addr_i = '0; wr_data_i = '0; ld_data_i = '0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    tick(); tick();
    reset_i = 1'b0;

    // Reset state, then a plain read of RAM[5].
    tick();
    chk("rst_ready", 64'(o_ld_ready), 64'(0));
    chk("rst_data",  64'(o_rd_data),  64'(0));
    rd_req_i = 1'b1; rd_addr_i = 11'd5;
    tick();
    chk("tp1_gnt", 64'(o_rd_gnt), 64'(1));
    chk("tp1_we",  64'(o_mem_we), 64'(0));
    rd_req_i = 1'b0;
    tick();
    chk("tp1_valid", 64'(o_rd_valid), 64'(1));
    chk("tp1_data",  64'(o_rd_data),  64'(32'h0000_1234));

    // Starvation guard: 4 writes, then the read, then writes again.
    rd_req_i = 1'b1; rd_addr_i = 11'd9;
    wr_req_i = 1'b1; wr_addr_i = 11'd20; wr_data_i = 32'h0BAD_F00D;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("tp2_rd", 64'(o_rd_gnt), 64'(i == 4));
      chk("tp2_wr", 64'(o_wr_gnt), 64'(i != 4));
    end
    idle();
    tick();

    // Write then read the same word.
    wr_req_i = 1'b1; wr_addr_i = 11'd7; wr_data_i = 32'hDEAD_BEEF;
    tick();
    chk("tp3_wgnt", 64'(o_wr_gnt),   64'(1));
    chk("tp3_we",   64'(o_mem_we),   64'(1));
    chk("tp3_addr", 64'(o_mem_addr), 64'(7));
    wr_req_i = 1'b0; rd_req_i = 1'b1; rd_addr_i = 11'd7;
    tick();
    chk("tp3_rgnt", 64'(o_rd_gnt), 64'(1));
    rd_req_i = 1'b0;
    tick();
    chk("tp3_valid", 64'(o_rd_valid), 64'(1));
    chk("tp3_data",  64'(o_rd_data),  64'(32'hDEAD_BEEF));

    // Read in flight, then the loader takes over.
    rd_req_i = 1'b1; rd_addr_i = 11'd3;
    tick();
    chk("tp4_rgnt", 64'(o_rd_gnt), 64'(1));
    ld_mode_i = 1'b1; rd_addr_i = 11'd4;
    wr_req_i = 1'b1; wr_addr_i = 11'd8; wr_data_i = 32'h1;
    ld_req_i = 1'b1; ld_addr_i = 11'd0; ld_data_i = 32'hC0DE_0000;
    tick();
    chk("tp4_nogrant", 64'({o_rd_gnt, o_wr_gnt, o_ld_gnt}), 64'(0));
    chk("tp4_valid",   64'(o_rd_valid), 64'(1));
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      chk("tp4_no_rdwr", 64'({o_rd_gnt, o_wr_gnt}), 64'(0));
      if (o_ld_ready) got = 1'b1;
      else chk("tp4_no_ld", 64'(o_ld_gnt), 64'(0));
    end
    chk("tp4_ready", 64'(got), 64'(1));
    chk("tp4_ld0",   64'(o_ld_gnt), 64'(1));
    for (int a = 1; a < 4; a++) begin
      ld_addr_i = 11'(a); ld_data_i = 32'hC0DE_0000 | 32'(a);
      tick();
      chk("tp4_ldgnt", 64'(o_ld_gnt),   64'(1));
      chk("tp4_addr",  64'(o_mem_addr), 64'(a));
      chk("tp4_rdwr",  64'({o_rd_gnt, o_wr_gnt}), 64'(0));
    end

    // Leave LOAD: one idle exit cycle, then the pending write wins.
    ld_mode_i = 1'b0; ld_req_i = 1'b0;
    tick();
    chk("tp5_exit", 64'({o_rd_gnt, o_wr_gnt, o_ld_gnt}), 64'(0));
    tick();
    chk("tp5_wgnt", 64'(o_wr_gnt), 64'(1));
    wr_req_i = 1'b0; rd_addr_i = 11'd2;
    tick();
    chk("tp5_rgnt", 64'(o_rd_gnt), 64'(1));
    rd_req_i = 1'b0;
    tick();
    chk("tp5_lddata", 64'(o_rd_data), 64'(32'hC0DE_0002));

    // Reset right after a read grant flushes it.
    rd_req_i = 1'b1; rd_addr_i = 11'd5;
    tick();
    chk("tp6_rgnt", 64'(o_rd_gnt), 64'(1));
    rd_req_i = 1'b0; reset_i = 1'b1;
    tick();
    chk("tp6_flush", 64'(o_rd_valid), 64'(0));
    reset_i = 1'b0;
    tick();
    chk("tp6_zero", 64'({o_rd_valid, o_ld_ready, o_mem_en, o_rd_gnt, o_wr_gnt, o_ld_gnt}), 64'(0));
    chk("tp6_data", 64'(o_rd_data), 64'(0));

    // Random traffic honouring the hold-until-grant handshake.
    for (int k = 0; k < 3000; k++) begin
      reset_i = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) ld_mode_i = ~ld_mode_i;
      if (!rd_req_i || e_rd) begin
        rd_req_i  = ($urandom_range(0, 9) < 6);
        rd_addr_i = 11'($urandom_range(0, 15));
      end
      if (!wr_req_i || e_wr) begin
        wr_req_i  = ($urandom_range(0, 9) < 5);
        wr_addr_i = 11'($urandom_range(0, 15));
        wr_data_i = $urandom();
      end
      if (!ld_req_i || e_ld) begin
        ld_req_i  = ($urandom_range(0, 9) < 5);
        ld_addr_i = 11'($urandom_range(0, 15));
        ld_data_i = $urandom();
      end
      if (reset_i) begin
        rd_req_i = 1'b0; wr_req_i = 1'b0; ld_req_i = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arima_mem_arbiter.md
Name: arima_mem_arbiter

Overview:
- Shares the single-port 2048x32 block RAM behind the ARIMA anomaly-detection core between three requesters: datapath sample reads, prediction write-back, and a host/loader port that fills sample data.
- Replaces the ad-hoc read/write address mux with a request/grant scheme, a starvation guard and read-data-valid tracking.
- A mode FSM gives the loader exclusive ownership only after outstanding reads drain.
- Sits between ARIMA_anomaly_detection, the loader and the memory, all on the 1 kHz core clock.

Parameters:
N, 32, data width of RAM words and all data ports
AW, 11, RAM address width
RD_LAT, 1, RAM read latency in cycles (1..3)
MAX_WAIT, 4, consecutive denied cycles after which a pending read overrides write priority

Ports:
clk  in  1  core clock (the divided 1 kHz clock at top level)
reset  in  1  synchronous, active-high reset
rd_req  in  1  datapath read request
rd_addr  in  AW  read address, stable while rd_req high
rd_gnt  out  1  read accepted this cycle
rd_data  out  N  read data
rd_valid  out  1  rd_data valid, one pulse per granted read
wr_req  in  1  prediction write-back request
wr_addr  in  AW  write address
wr_data  in  N  write data
wr_gnt  out  1  write performed this cycle
ld_mode  in  1  loader requests exclusive ownership
ld_req  in  1  loader write request (honoured only in LOAD)
ld_addr  in  AW  loader address
ld_data  in  N  loader data
ld_gnt  out  1  loader write performed this cycle
ld_ready  out  1  arbiter is in LOAD
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_din  out  N  RAM write data
mem_dout  in  N  RAM read data, RD_LAT cycles after the address

Behaviour:
- Handshake: a requester holds req, addr and data stable until it sees gnt. A transfer occurs in the cycle gnt=1. Grants are combinational from the current req and state. RAM signals are driven combinationally from the winner and sampled by the RAM on the next clk edge.
- At most one grant per cycle. With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Reset values: all gnt/valid outputs 0, ld_ready=0, rd_data=0, state RUN, wait counter 0, read pipeline empty.
- FSM states:
  - RUN: arbitrates rd/wr. Write wins over read unless wait_cnt==MAX_WAIT, in which case read wins. If ld_mode=1, no grant is issued this cycle and the next state is DRAIN.
  - DRAIN: no grants. Go to LOAD when the read pipeline is empty, i.e. all granted reads have produced rd_valid. If ld_mode drops first, return to RUN.
  - LOAD: ld_ready=1. ld_gnt=ld_req. rd/wr are never granted. When ld_mode=0, go to RUN next cycle; no grant is issued in that exit cycle.
- wait_cnt:
  - Increments while rd_req=1 and rd_gnt=0 in RUN. Saturates at MAX_WAIT.
  - Clears on rd_gnt or when rd_req=0.
  - Holds its value in DRAIN and LOAD.
- Read tracking:
  - An RD_LAT-deep valid shift register records each rd_gnt.
  - rd_valid asserts exactly RD_LAT cycles after rd_gnt.
  - rd_data is mem_dout in that cycle. It is registered to hold its value when rd_valid=0.
  - Back-to-back reads give back-to-back rd_valid.
- A simultaneous rd_req and wr_req to the same address, with write winning, means the later read returns the new data. No bypass is needed.
- Reset asserted mid-operation flushes the pipeline: no rd_valid for reads already granted. The state returns to RUN.
- ld_req in RUN or DRAIN is ignored (no ld_gnt); it stays pending until LOAD.

Optional Feature:
- Macro: ARIMA_MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs rd_cnt, wr_cnt, ld_cnt and stall_cnt, each 16 bits.
  - rd_cnt, wr_cnt and ld_cnt count grants per requester.
  - stall_cnt counts RUN cycles with a pending request and no grant.
  - All four saturate at 16'hFFFF and clear on reset. They are intended for the 7-segment debug display.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package arima_mem_pkg holds:
  - typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} arb_state_t;
  - localparams for default AW and N.
  - typedef for the grant one-hot {ld, wr, rd}.
- Sub-module rd_valid_pipe: parameterised RD_LAT shift register with a synchronous flush. It owns rd_valid and the rd_data capture.

Test Plan:
- Reset then rd_req at addr 5 with RAM[5]=32'h0000_1234: rd_gnt the same cycle; rd_valid one cycle later with rd_data=32'h1234; mem_we=0.
- rd_req and wr_req held continuously (MAX_WAIT=4): wr_gnt for 4 cycles, rd_gnt on the 5th, wait_cnt back to 0, then wr_gnt again.
- wr_req addr 7 data 32'hDEAD_BEEF, then rd_req addr 7: mem_we pulse with addr 7, then rd_valid with 32'hDEADBEEF.
- Read granted, then ld_mode=1 the next cycle: DRAIN until rd_valid fires, then ld_ready=1. A concurrent rd_req or wr_req gets no grant. ld_req writes addr 0..3 with ld_gnt each cycle.
- ld_mode deasserted: one idle cycle, then RUN; a pending wr_req is granted on the following cycle.
- Reset pulsed one cycle after rd_gnt: no rd_valid follows, and all outputs are 0 in the cycle after reset.
